seg7_decoder: RTL and testbench

//   Registered 4-bit to 7-segment decoder for one seven-segment digit.
//   The traffic controller uses two instances: ones and tens of the countdown

---
 rtl/seg7_decoder.sv | 76 +++++++
 tb/tb_seg7_decoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seg7_decoder.sv
// Registered 4-bit to 7-segment decoder for a single digit.
// The output register is the only state; the polarity and hex-digit options are fixed at elaboration.
module seg7_decoder #(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit HEX_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // All patterns are held in active-low form, bits {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_OFF_AL = 7'b1111111;

    logic [6:0] pattern_al;
    logic [6:0] seg_next;
    logic [6:0] seg_reg;
    logic       digit_is_hex;

    assign digit_is_hex = (digit > 4'd9);

    always_comb begin
        pattern_al = SEG_OFF_AL;
        if (blank) begin
            pattern_al = SEG_OFF_AL;
        end else if (digit_is_hex && !HEX_EN) begin
            pattern_al = SEG_OFF_AL;
        end else begin
            case (digit)
                4'h0:    pattern_al = 7'b1000000;
                4'h1:    pattern_al = 7'b1111001;
                4'h2:    pattern_al = 7'b0100100;
                4'h3:    pattern_al = 7'b0110000;
                4'h4:    pattern_al = 7'b0011001;
                4'h5:    pattern_al = 7'b0010010;
                4'h6:    pattern_al = 7'b0000010;
                4'h7:    pattern_al = 7'b1111000;
                4'h8:    pattern_al = 7'b0000000;
                4'h9:    pattern_al = 7'b0010000;
                4'hA:    pattern_al = 7'b0001000;
                4'hB:    pattern_al = 7'b0000011;
                4'hC:    pattern_al = 7'b1000110;
                4'hD:    pattern_al = 7'b0100001;
                4'hE:    pattern_al = 7'b0000110;
                4'hF:    pattern_al = 7'b0001110;
                // Unknown or undefined codes fall back to a dark digit.
                default: pattern_al = SEG_OFF_AL;
            endcase
        end
    end

    // Active-high boards take the inverse of every pattern, the off pattern included.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_polarity
            if (ACTIVE_LOW) begin : g_low
                assign seg_next[gi] = pattern_al[gi];
            end else begin : g_high
                assign seg_next[gi] = ~pattern_al[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_reg <= ACTIVE_LOW ? SEG_OFF_AL : ~SEG_OFF_AL;
        end else begin
            seg_reg <= seg_next;
        end
    end

    assign seg = seg_reg;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder: default, HEX_EN=0 and ACTIVE_LOW=0 instances,
// plus a tens/ones pair driven by a countdown.
module tb_seg7_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit_a;
    logic [3:0] digit_b;
    logic       blank;
    logic [6:0] seg_ones;
    logic [6:0] seg_tens;
    logic [6:0] seg_nohex;
    logic [6:0] seg_high;

    int checks = 0;
    int errors = 0;

    // Hand-written active-low table, index = digit.
    logic [6:0] table_al [16];
    initial begin
        table_al[0]  = 7'h40; table_al[1]  = 7'h79; table_al[2]  = 7'h24; table_al[3]  = 7'h30;
        table_al[4]  = 7'h19; table_al[5]  = 7'h12; table_al[6]  = 7'h02; table_al[7]  = 7'h78;
        table_al[8]  = 7'h00; table_al[9]  = 7'h10; table_al[10] = 7'h08; table_al[11] = 7'h03;
        table_al[12] = 7'h46; table_al[13] = 7'h21; table_al[14] = 7'h06; table_al[15] = 7'h0E;
    end

    always #5 clk = ~clk;

    seg7_decoder u_ones (
        .clk(clk), .reset(reset), .digit(digit_a), .blank(blank), .seg(seg_ones)
    );
    seg7_decoder u_tens (
        .clk(clk), .reset(reset), .digit(digit_b), .blank(blank), .seg(seg_tens)
    );
    seg7_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u_nohex (
        .clk(clk), .reset(reset), .digit(digit_a), .blank(blank), .seg(seg_nohex)
    );
    seg7_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_high (
        .clk(clk), .reset(reset), .digit(digit_a), .blank(blank), .seg(seg_high)
    );

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] prev_ones;
    logic [6:0] exp_nohex;
    int tens_v;
    int ones_v;

    initial begin
        reset   = 1'b0;
        digit_a = 4'd8;
        digit_b = 4'd8;
        blank   = 1'b0;

        for (int c = 0; c < 2; c++) begin
            step();
            check($sformatf("reset_ones_c%0d", c), seg_ones, 7'h7F);
            check($sformatf("reset_nohex_c%0d", c), seg_nohex, 7'h7F);
            check($sformatf("reset_high_c%0d", c), seg_high, 7'h00);
        end

        reset = 1'b1;
        prev_ones = 7'h7F;
        for (int d = 0; d < 16; d++) begin
            digit_a = 4'(d);
            #1;
            // Output must not react before the next edge.
            check($sformatf("hold_before_edge_d%0d", d), seg_ones, prev_ones);
            step();
            exp_nohex = (d > 9) ? 7'h7F : table_al[d];
            check($sformatf("sweep_ones_d%0d", d), seg_ones, table_al[d]);
            check($sformatf("sweep_nohex_d%0d", d), seg_nohex, exp_nohex);
            check($sformatf("sweep_high_d%0d", d), seg_high, ~table_al[d]);
            prev_ones = table_al[d];
        end

        digit_a = 4'd2;
        blank   = 1'b1;
        step();
        check("blank_ones", seg_ones, 7'h7F);
        check("blank_high", seg_high, 7'h00);
        blank = 1'b0;
        step();
        check("unblank_ones", seg_ones, 7'h24);
        check("unblank_high", seg_high, 7'h5B);

        // HEX_EN=0 instance, directed.
        digit_a = 4'd12;
        step();
        check("nohex_d12", seg_nohex, 7'h7F);
        digit_a = 4'd9;
        step();
        check("nohex_d9", seg_nohex, 7'h10);

        // Reset wins over blank; active-high off is all zeros.
        reset = 1'b0;
        blank = 1'b1;
        step();
        check("reset_over_blank_ones", seg_ones, 7'h7F);
        check("reset_over_blank_high", seg_high, 7'h00);
        blank   = 1'b0;
        digit_a = 4'd1;
        step();
        check("reset_hold_high", seg_high, 7'h00);
        reset = 1'b1;
        step();
        check("first_after_reset_high_d1", seg_high, 7'h06);
        check("first_after_reset_ones_d1", seg_ones, 7'h79);

        // Countdown 20..0 on the tens/ones pair with a reset pulse mid-count.
        for (int n = 20; n >= 0; n--) begin
            tens_v  = n / 10;
            ones_v  = n % 10;
            digit_b = 4'(tens_v);
            digit_a = 4'(ones_v);
            step();
            check($sformatf("count_tens_n%0d", n), seg_tens, table_al[tens_v]);
            check($sformatf("count_ones_n%0d", n), seg_ones, table_al[ones_v]);
            if (n == 10) begin
                reset = 1'b0;
                step();
                check("midcount_reset_tens", seg_tens, 7'h7F);
                check("midcount_reset_ones", seg_ones, 7'h7F);
                reset = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
